// File: rtl/ssp_tx_sequencer.sv
// TI-style synchronous serial transmit sequencer: drains the TxFIFO one word per frame,
// emitting a one-bit-period frame pulse followed by DATA_WIDTH bits, MSB first.
module ssp_tx_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  SSE,
  input  logic                  TX_EMPTY,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_POP,
  output logic                  SSPTXD,
  output logic                  SSPFSSOUT,
  output logic                  SSPCLKOUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int unsigned BP = 2 * CLK_DIV;
  localparam int unsigned DW = (BP > 1) ? $clog2(BP) : 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DW-1:0]         div_cnt, div_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic                  pop_n, txd_n, fss_n, clk_n, busy_n, done_n;
  logic                  wrap, last, load;

  // State, counters, shift register and all outputs are registered together
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      TX_POP    <= 1'b0;
      SSPTXD    <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPCLKOUT <= 1'b0;
      BUSY      <= 1'b0;
      TX_DONE   <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      TX_POP    <= pop_n;
      SSPTXD    <= txd_n;
      SSPFSSOUT <= fss_n;
      SSPCLKOUT <= clk_n;
      BUSY      <= busy_n;
      TX_DONE   <= done_n;
    end
  end

  // Next-state and next-output logic; a load (from IDLE or end of last bit) overrides
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    pop_n   = 1'b0;
    txd_n   = 1'b0;
    fss_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;
    wrap    = (div_cnt == DW'(BP - 1));
    last    = (bit_cnt == BW'(DATA_WIDTH - 1));

    case (state)
      S_IDLE: begin
        div_n = '0;
        bit_n = '0;
        load  = SSE && !TX_EMPTY;
      end
      S_FRAME: begin
        busy_n = 1'b1;
        fss_n  = 1'b1;
        div_n  = wrap ? '0 : div_cnt + DW'(1);
        if (wrap) begin
          state_n = S_SHIFT;
          fss_n   = 1'b0;
          txd_n   = shift_reg[DATA_WIDTH-1];
          shift_n = shift_reg << 1;
          bit_n   = '0;
        end
      end
      S_SHIFT: begin
        busy_n = 1'b1;
        txd_n  = SSPTXD;
        div_n  = wrap ? '0 : div_cnt + DW'(1);
        if (wrap) begin
          if (last) begin
            done_n = 1'b1;
            bit_n  = '0;
            if (SSE && !TX_EMPTY) begin
              load = 1'b1;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
              txd_n   = 1'b0;
            end
          end else begin
            bit_n   = bit_cnt + BW'(1);
            txd_n   = shift_reg[DATA_WIDTH-1];
            shift_n = shift_reg << 1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (load) begin
      state_n = S_FRAME;
      shift_n = TX_DATA;
      pop_n   = 1'b1;
      fss_n   = 1'b1;
      busy_n  = 1'b1;
      txd_n   = 1'b0;
      div_n   = '0;
      bit_n   = '0;
    end

    // Serial clock tracks the registered divider: low first half-bit, high second
    clk_n = (state_n != S_IDLE) && (div_n >= DW'(CLK_DIV));
  end

endmodule

// File: tb/tb_ssp_tx_sequencer.sv
// Self-checking bench for ssp_tx_sequencer: FIFO model, serial receiver model and
// cycle-level frame waveform expectations derived from bit-period arithmetic.
module tb_ssp_tx_sequencer;

  localparam int W     = 8;
  localparam int CDIV  = 2;
  localparam int BP    = 2 * CDIV;
  localparam int FLEN  = (W + 1) * BP;

  logic         pclk;
  logic         clear;
  logic         sse;
  logic         tx_empty;
  logic [W-1:0] tx_data;
  logic         tx_pop, ssptxd, sspfssout, sspclkout, busy, tx_done;
  logic [5:0]   outs;

  assign outs = {tx_pop, sspfssout, ssptxd, sspclkout, busy, tx_done};

  ssp_tx_sequencer #(.DATA_WIDTH(W), .CLK_DIV(CDIV)) dut (
    .PCLK      (pclk),
    .CLEAR     (clear),
    .SSE       (sse),
    .TX_EMPTY  (tx_empty),
    .TX_DATA   (tx_data),
    .TX_POP    (tx_pop),
    .SSPTXD    (ssptxd),
    .SSPFSSOUT (sspfssout),
    .SSPCLKOUT (sspclkout),
    .BUSY      (busy),
    .TX_DONE   (tx_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // FIFO model: pushes from stimulus at negedge, visible to the DUT after the next posedge
  logic [W-1:0] fifo[$];
  logic [W-1:0] exp_q[$];

  always @(posedge pclk) begin
    #1;
    if (fifo.size() != 0) begin
      tx_empty = 1'b0;
      tx_data  = fifo[0];
    end else begin
      tx_empty = 1'b1;
      tx_data  = '0;
    end
  end

  // Monitor: pop bookkeeping, completion latency, and a serial receiver on SSPCLKOUT rises
  int           cyc = 0;
  int           pop_cyc = 0;
  int           n_pop = 0;
  int           n_done = 0;
  int           n_rx = 0;
  int           nbits = 0;
  bit           in_frame = 0;
  bit           prev_clk = 0;
  bit           prev_pop = 0;
  logic [W-1:0] rx = '0;

  always @(negedge pclk) begin
    cyc++;
    if (clear) begin
      in_frame = 0;
      prev_clk = 0;
      prev_pop = 0;
      exp_q.delete();
    end else begin
      if (tx_done) begin
        n_done++;
        check("done_latency", 32'(cyc - pop_cyc), 32'(FLEN));
      end
      if (tx_pop) begin
        check("pop_gap", 32'(prev_pop), 32'd0);
        check("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
        if (fifo.size() != 0) exp_q.push_back(fifo.pop_front());
        n_pop++;
        pop_cyc = cyc;
      end
      prev_pop = tx_pop;
      if (sspclkout && !prev_clk) begin
        if (sspfssout) begin
          in_frame = 1;
          nbits    = 0;
          rx       = '0;
        end else if (in_frame) begin
          rx = {rx[W-2:0], ssptxd};
          nbits++;
          if (nbits == W) begin
            in_frame = 0;
            n_rx++;
            if (exp_q.size() == 0) check("rx_word_expected", 32'd0, 32'd1);
            else check("rx_word", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
      prev_clk = sspclkout;
    end
  end

  // Expected {pop,fss,txd,clk,busy,done} k cycles after the first pop of an n-word burst
  logic [W-1:0] dir_words [2];

  function automatic logic [5:0] exp_vec(input int k, input int n);
    int f, kk;
    logic [W-1:0] w;
    logic p, fs, d, c, b, dn;
    f  = k / FLEN;
    kk = k % FLEN;
    if (f >= n) return 6'b000001;
    w  = dir_words[f];
    p  = (kk == 0);
    fs = (kk < BP);
    d  = (kk >= BP) ? w[W - 1 - (kk - BP) / BP] : 1'b0;
    c  = ((kk % BP) >= CDIV);
    b  = 1'b1;
    dn = (kk == 0) && (f > 0);
    return {p, fs, d, c, b, dn};
  endfunction

  task automatic check_frames(input int n);
    for (int k = 0; k <= FLEN * n; k++) begin
      if (k > 0) @(negedge pclk);
      check($sformatf("frame_k%0d", k), 32'(outs), 32'(exp_vec(k, n)));
    end
  endtask

  task automatic wait_pop(input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk);
      if (tx_pop) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit got;
    int p0, d0, r0, pushed;

    // Reset with random inputs
    clear    = 1'b1;
    tx_empty = 1'b1;
    tx_data  = '0;
    sse      = 1'($urandom);
    fifo.push_back(W'($urandom));
    repeat (3) @(negedge pclk);
    check("reset_outputs", 32'(outs), 32'd0);
    fifo.delete();
    sse = 1'b1;
    repeat (2) @(negedge pclk);
    clear = 1'b0;
    p0  = n_pop;
    got = 0;
    repeat (100) begin
      @(negedge pclk);
      if (busy) got = 1;
    end
    check("empty_no_pop", 32'(n_pop - p0), 32'd0);
    check("empty_no_busy", 32'(got), 32'd0);

    // Single word 0xA5
    dir_words[0] = 8'hA5;
    d0 = n_done;
    fifo.push_back(8'hA5);
    wait_pop("single_pop", ok);
    if (ok) check_frames(1);
    @(negedge pclk);
    check("single_done_count", 32'(n_done - d0), 32'd1);

    // Back-to-back words 0x01, 0x80
    dir_words[0] = 8'h01;
    dir_words[1] = 8'h80;
    p0 = n_pop;
    fifo.push_back(8'h01);
    fifo.push_back(8'h80);
    wait_pop("b2b_pop", ok);
    if (ok) check_frames(2);
    @(negedge pclk);
    check("b2b_pop_count", 32'(n_pop - p0), 32'd2);

    // SSE gating, then SSE dropped during bit 3
    sse = 1'b0;
    p0  = n_pop;
    fifo.push_back(8'h3C);
    fifo.push_back(8'hC3);
    repeat (60) @(negedge pclk);
    check("sse_off_no_pop", 32'(n_pop - p0), 32'd0);
    d0  = n_done;
    sse = 1'b1;
    wait_pop("sse_on_pop", ok);
    repeat (17) @(negedge pclk);
    sse = 1'b0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge pclk);
      if (tx_done) got = 1;
    end
    check("sse_drop_done", 32'(got), 32'd1);
    repeat (60) @(negedge pclk);
    check("sse_drop_pops", 32'(n_pop - p0), 32'd1);
    check("sse_drop_done_count", 32'(n_done - d0), 32'd1);
    fifo.delete();

    // CLEAR during bit 4, then restart with the current head word
    fifo.push_back(8'h96);
    fifo.push_back(8'h69);
    sse = 1'b1;
    wait_pop("clear_first_pop", ok);
    repeat (21) @(negedge pclk);
    #2 clear = 1'b1;
    #1 check("clear_async_outputs", 32'(outs), 32'd0);
    d0 = n_done;
    repeat (3) @(negedge pclk);
    clear = 1'b0;
    dir_words[0] = 8'h69;
    wait_pop("clear_restart_pop", ok);
    check("clear_no_done", 32'(n_done - d0), 32'd0);
    if (ok) check_frames(1);
    @(negedge pclk);

    // Random traffic: random fill gaps and random SSE toggling
    p0 = n_pop;
    d0 = n_done;
    r0 = n_rx;
    pushed = 0;
    for (int c = 0; c < 40000 && (n_rx - r0) < 200; c++) begin
      @(negedge pclk);
      if (pushed < 200 && $urandom_range(0, 29) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)) && pushed < 200; j++) begin
          fifo.push_back(W'($urandom));
          pushed++;
        end
      end
      if (pushed >= 200) sse = 1'b1;
      else if ($urandom_range(0, 99) == 0) sse = ~sse;
    end
    repeat (5) @(negedge pclk);
    check("rand_words_received", 32'(n_rx - r0), 32'd200);
    check("rand_pops_eq_dones", 32'(n_pop - p0), 32'(n_done - d0));
    check("rand_pop_count", 32'(n_pop - p0), 32'd200);
    check("rand_exp_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle_at_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
